io_bus_scheduler: RTL and testbench

Shares the single non-cacheable I/O bus between per-core I/O request ports. Grants one outstanding transaction at a time using round-robin order, drives the bus strobe, and waits for the device acknowledge or a timeout. It then returns the read data, tagged with the requester index, on a shared response channel. It sits between the cores' I/O request outputs and the top-level `io_*` pins.

---
 rtl/io_bus_scheduler_pkg.sv | 28 ++
 rtl/io_bus_scheduler_rr_arbiter.sv | 39 +++
 rtl/io_bus_scheduler.sv | 174 +++++++++++++++++
 tb/tb_io_bus_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_scheduler_pkg.sv
// Shared types and constants for the non-cacheable I/O bus scheduler.
package io_bus_scheduler_pkg;

  // Default number of cores sharing the I/O bus.
  localparam int NUM_CORES = 4;

  // Width of a machine word on the I/O bus.
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] scalar_t;

  // Scheduler phases: pick a requester, strobe the bus, wait for ack, respond.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } io_sched_state_t;

  // Read data returned when the device never acknowledges.
  localparam scalar_t TIMEOUT_DATA = 32'hFFFF_FFFF;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_bus_scheduler_rr_arbiter.sv
// Round-robin selector: picks the first set request strictly after last_grant,
// wrapping modulo WIDTH, and reports it both one-hot and as an index.
module io_bus_scheduler_rr_arbiter
  import io_bus_scheduler_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [WIDTH-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // One spare bit so last_grant + offset never overflows before the wrap.
  logic [IDX_W:0] cand;

  // Scan offsets from farthest to nearest; the last hit written is the nearest
  // valid requester after last_grant, which is the round-robin winner.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = |req;
    cand        = '0;
    for (int off = WIDTH; off >= 1; off--) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(WIDTH)) begin
        cand = cand - (IDX_W+1)'(WIDTH);
      end
      if (req[cand[IDX_W-1:0]]) begin
        grant                   = '0;
        grant[cand[IDX_W-1:0]]  = 1'b1;
        grant_idx               = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/io_bus_scheduler.sv
// Shares the single non-cacheable I/O bus between per-core request ports.
// One transaction is outstanding at a time; requesters are served round-robin,
// the bus is strobed for one cycle, and the result (device data or a timeout
// marker) is returned on a shared response channel tagged with the requester.
module io_bus_scheduler
  import io_bus_scheduler_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CORES,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int REQ_IDX_W = idx_width(NUM_REQUESTERS)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQUESTERS-1:0]              req_valid,
  input  logic [NUM_REQUESTERS-1:0]              req_store,
  input  logic [NUM_REQUESTERS-1:0][DATA_W-1:0]  req_address,
  input  logic [NUM_REQUESTERS-1:0][DATA_W-1:0]  req_write_data,
  output logic [NUM_REQUESTERS-1:0]              req_ready,
  output logic                                   rsp_valid,
  output logic [REQ_IDX_W-1:0]                   rsp_requester,
  output logic [DATA_W-1:0]                      rsp_read_data,
  output logic                                   rsp_timeout,
  output logic                                   io_write_en,
  output logic                                   io_read_en,
  output logic [DATA_W-1:0]                      io_address,
  output logic [DATA_W-1:0]                      io_write_data,
  input  logic                                   io_ack,
  input  logic [DATA_W-1:0]                      io_read_data
);

  // Counter saturates at the timeout value; the timeout fires one below it so
  // that the response lands TIMEOUT_CYCLES + 2 cycles after the accept.
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT_CYCLES - 1);

  io_sched_state_t state_q, state_d;

  logic [REQ_IDX_W-1:0]      last_grant_q;
  logic [REQ_IDX_W-1:0]      owner_q;
  logic                      store_q;
  logic [DATA_W-1:0]         addr_q;
  logic [DATA_W-1:0]         wdata_q;
  logic [DATA_W-1:0]         rdata_q;
  logic                      timeout_q;
  logic [15:0]               wait_count_q;

  logic [NUM_REQUESTERS-1:0] arb_grant;
  logic [REQ_IDX_W-1:0]      arb_idx;
  logic                      arb_valid;

  logic                      accept;
  logic                      ack_taken;
  logic                      timeout_hit;

  io_bus_scheduler_rr_arbiter #(
    .WIDTH (NUM_REQUESTERS),
    .IDX_W (REQ_IDX_W)
  ) u_rr_arbiter (
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Next-state logic and the single-cycle pulses (accept, strobes, response).
  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    io_write_en = 1'b0;
    io_read_en  = 1'b0;
    rsp_valid   = 1'b0;
    accept      = 1'b0;
    ack_taken   = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated by reset so no accept pulse is visible while reset is held.
        if (arb_valid && reset) begin
          accept    = 1'b1;
          req_ready = arb_grant;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        io_write_en = store_q;
        io_read_en  = !store_q;
        if (io_ack) begin
          ack_taken = 1'b1;
          state_d   = RESPOND;
        end else begin
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // A late ack on the final wait cycle still wins over the timeout.
        if (io_ack) begin
          ack_taken   = 1'b1;
          state_d     = RESPOND;
        end else if (wait_count_q == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = RESPOND;
        end
      end
      RESPOND: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM register and the round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_IDX_W'(NUM_REQUESTERS - 1);
    end else begin
      state_q <= state_d;
      if (state_q == RESPOND) begin
        last_grant_q <= owner_q;
      end
    end
  end

  // Latch the granted request; these drive the bus until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= '0;
      store_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      owner_q <= arb_idx;
      store_q <= req_store[arb_idx];
      addr_q  <= req_address[arb_idx];
      wdata_q <= req_write_data[arb_idx];
    end
  end

  // Capture the transaction outcome: device data on ack, marker on timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      timeout_q <= 1'b0;
    end else if (ack_taken) begin
      rdata_q   <= io_read_data;
      timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      rdata_q   <= TIMEOUT_DATA;
      timeout_q <= 1'b1;
    end
  end

  // Wait counter: cleared while strobing, counts (saturating) while waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_count_q <= '0;
    end else if (state_q == ISSUE) begin
      wait_count_q <= '0;
    end else if (state_q == WAIT && wait_count_q < WAIT_LIMIT) begin
      wait_count_q <= wait_count_q + 16'd1;
    end
  end

  assign rsp_requester = owner_q;
  assign rsp_read_data = rdata_q;
  assign rsp_timeout   = timeout_q;
  assign io_address    = addr_q;
  assign io_write_data = wdata_q;

endmodule

// File: tb/tb_io_bus_scheduler.sv
// Bench for io_bus_scheduler: randomized request rounds with a device model,
// a round-robin reference model and a scoreboard-style monitor.
module tb_io_bus_scheduler;

  localparam int N  = 4;
  localparam int TO = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_store;
  logic [N-1:0][31:0]   req_address;
  logic [N-1:0][31:0]   req_write_data;
  logic [N-1:0]         req_ready;
  logic                 rsp_valid;
  logic [1:0]           rsp_requester;
  logic [31:0]          rsp_read_data;
  logic                 rsp_timeout;
  logic                 io_write_en;
  logic                 io_read_en;
  logic [31:0]          io_address;
  logic [31:0]          io_write_data;
  logic                 io_ack;
  logic [31:0]          io_read_data;

  io_bus_scheduler #(
    .NUM_REQUESTERS (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .req_valid      (req_valid),
    .req_store      (req_store),
    .req_address    (req_address),
    .req_write_data (req_write_data),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_requester  (rsp_requester),
    .rsp_read_data  (rsp_read_data),
    .rsp_timeout    (rsp_timeout),
    .io_write_en    (io_write_en),
    .io_read_en     (io_read_en),
    .io_address     (io_address),
    .io_write_data  (io_write_data),
    .io_ack         (io_ack),
    .io_read_data   (io_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One planned transaction: who asks, what, and how the device will answer
  // (d = ack delay in cycles after the strobe cycle).
  typedef struct {
    int          port;
    logic        store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          d;
  } txn_t;

  txn_t iss_q[$];
  txn_t rsp_q[$];
  txn_t plan[N];

  int   model_last = N - 1;
  int   compared   = 0;
  int   mismatched = 0;

  bit          round_first = 1'b0;
  bit          dev_busy    = 1'b0;
  int          accept_cyc  = 0;
  int          strobe_cyc  = 0;
  int          last_rsp_cyc = 0;
  int          ack_cnt     = -1;
  logic [31:0] dev_data    = '0;
  logic [N-1:0] acc_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req_ready"},     32'(req_ready),     32'd0);
    chk({tag, "_rsp_valid"},     32'(rsp_valid),     32'd0);
    chk({tag, "_rsp_requester"}, 32'(rsp_requester), 32'd0);
    chk({tag, "_rsp_read_data"}, rsp_read_data,      32'd0);
    chk({tag, "_rsp_timeout"},   32'(rsp_timeout),   32'd0);
    chk({tag, "_io_write_en"},   32'(io_write_en),   32'd0);
    chk({tag, "_io_read_en"},    32'(io_read_en),    32'd0);
    chk({tag, "_io_address"},    io_address,         32'd0);
    chk({tag, "_io_write_data"}, io_write_data,      32'd0);
  endtask

  task automatic plan_random();
    for (int p = 0; p < N; p++) begin
      plan[p].port  = p;
      plan[p].store = 1'($urandom_range(0, 1));
      plan[p].addr  = $urandom;
      plan[p].wdata = $urandom;
      plan[p].rdata = $urandom;
      plan[p].d     = $urandom_range(0, TO + 1);
    end
  endtask

  // Reference model: every port in mask is held until served, so service order
  // is the mask walked cyclically starting just after the last served port.
  task automatic launch(input logic [N-1:0] mask);
    int base;
    int p;
    @(posedge clk);
    #2;
    base = model_last;
    for (int k = 1; k <= N; k++) begin
      p = (base + k) % N;
      if (mask[p]) begin
        iss_q.push_back(plan[p]);
        rsp_q.push_back(plan[p]);
        model_last = p;
      end
    end
    round_first = 1'b1;
    for (int q = 0; q < N; q++) begin
      if (mask[q]) begin
        req_store[q]      = plan[q].store;
        req_address[q]    = plan[q].addr;
        req_write_data[q] = plan[q].wdata;
      end
    end
    req_valid = req_valid | mask;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("round_complete_pending", 32'(rsp_q.size()), 32'd0);
    if (rsp_q.size() != 0) begin
      // Recover from a stuck round so the remaining rounds still run.
      rst_n = 1'b0;
      req_valid = '0;
      iss_q.delete();
      rsp_q.delete();
      model_last = N - 1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
    end
  endtask

  // Requesters hold their request until they see req_ready, then drop it.
  initial begin
    forever begin
      @(negedge clk);
      acc_seen = req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc_seen;
    end
  end

  // Device model and monitor: accepts, strobes and responses are compared with
  // the expected queues; the device answers each strobe after its planned delay.
  initial begin
    txn_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        io_ack   = 1'b0;
        ack_cnt  = -1;
        dev_busy = 1'b0;
      end else begin
        if (req_ready != '0) begin
          chk("accept_expected", 32'(iss_q.size() != 0), 32'd1);
          if (iss_q.size() != 0) begin
            chk("accept_port", 32'(req_ready), 32'(1) << iss_q[0].port);
            chk("accept_while_busy", 32'(dev_busy), 32'd0);
            if (!round_first) chk("accept_cadence", 32'(cyc), 32'(last_rsp_cyc + 1));
          end
          round_first = 1'b0;
          accept_cyc  = cyc;
        end
        if (io_read_en || io_write_en) begin
          chk("strobe_expected", 32'(iss_q.size() != 0), 32'd1);
          chk("strobe_while_busy", 32'(dev_busy), 32'd0);
          if (iss_q.size() != 0) begin
            e = iss_q.pop_front();
            chk("strobe_write_en", 32'(io_write_en), 32'(e.store));
            chk("strobe_read_en", 32'(io_read_en), 32'(!e.store));
            chk("strobe_latency", 32'(cyc), 32'(accept_cyc + 1));
            chk("strobe_address", io_address, e.addr);
            chk("strobe_write_data", io_write_data, e.wdata);
            strobe_cyc = cyc;
            dev_busy   = 1'b1;
            ack_cnt    = e.d;
            dev_data   = e.rdata;
          end
        end
        if (rsp_valid) begin
          chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
          if (rsp_q.size() != 0) begin
            e   = rsp_q.pop_front();
            lat = (e.d <= TO) ? e.d + 1 : TO + 1;
            chk("rsp_requester", 32'(rsp_requester), 32'(e.port));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.d > TO));
            chk("rsp_read_data", rsp_read_data, (e.d <= TO) ? e.rdata : 32'hFFFF_FFFF);
            chk("rsp_latency", 32'(cyc), 32'(strobe_cyc + lat));
            chk("addr_stable", io_address, e.addr);
            chk("wdata_stable", io_write_data, e.wdata);
          end
          dev_busy     = 1'b0;
          last_rsp_cyc = cyc;
        end
        if (ack_cnt == 0) begin
          io_ack       = 1'b1;
          io_read_data = dev_data;
          ack_cnt      = -1;
        end else if (ack_cnt > 0) begin
          io_ack       = 1'b0;
          io_read_data = $urandom;
          ack_cnt--;
        end else begin
          // Nothing outstanding at the device: random acks must be ignored.
          io_ack       = 1'($urandom_range(0, 1));
          io_read_data = $urandom;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got cycle %0d, expected completion", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] m;
    int n;
    rst_n          = 1'b0;
    req_valid      = '0;
    req_store      = '0;
    req_address    = '0;
    req_write_data = '0;
    io_ack         = 1'b0;
    io_read_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("por");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Fairness: ports 0, 1, 3 with immediate ack, two back-to-back rounds.
    for (int r = 0; r < 2; r++) begin
      plan_random();
      for (int p = 0; p < N; p++) plan[p].d = 0;
      launch(4'b1011);
      wait_done(100);
    end

    // Single read on port 2 with a 3-cycle ack delay.
    plan_random();
    plan[2].store = 1'b0; plan[2].addr = 32'h80; plan[2].rdata = 32'h1234; plan[2].d = 3;
    launch(4'b0100);
    wait_done(100);

    // Timeout: device never answers in time.
    plan_random();
    plan[1].store = 1'b0; plan[1].d = TO + 1;
    launch(4'b0010);
    wait_done(100);

    // Ack on the very cycle the timeout would fire.
    plan_random();
    plan[3].store = 1'b0; plan[3].rdata = 32'hCAFE_F00D; plan[3].d = TO;
    launch(4'b1000);
    wait_done(100);

    // Store from port 0.
    plan_random();
    plan[0].store = 1'b1; plan[0].addr = 32'h40; plan[0].wdata = 32'hDEAD; plan[0].d = 2;
    launch(4'b0001);
    wait_done(100);

    // Randomized rounds.
    for (int r = 0; r < 30; r++) begin
      plan_random();
      m = 4'($urandom_range(1, 15));
      launch(m);
      wait_done(200);
    end

    // Reset while waiting for a slow device.
    plan_random();
    plan[1].store = 1'b0; plan[1].d = TO + 1;
    launch(4'b0010);
    n = 0;
    while (!dev_busy && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("reset_test_strobe_seen", 32'(dev_busy), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    req_valid = '0;
    iss_q.delete();
    rsp_q.delete();
    model_last = N - 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // After reset, port 0 must be served first.
    plan_random();
    launch(4'b1111);
    wait_done(200);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
